// File: rtl/uart_pkg.sv
// Shared definitions for the UART block serializers (rx_shift / tx_shift).
// Holds the common FSM state encodings, the byte width and the default
// number of bytes per block.
package uart_pkg;

    localparam int BYTE_W        = 8;
    localparam int DEF_NUM_BYTES = 16;
    localparam int ST_W          = 3;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_START = 3'd1;
    localparam logic [ST_W-1:0] ST_WAIT  = 3'd2;
    localparam logic [ST_W-1:0] ST_GAP   = 3'd3;
    localparam logic [ST_W-1:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/tx_shift.sv
// tx_shift: serializes one block from tx_buffer into bytes for the UART
// transmitter, most significant byte first, using a start/done handshake.
//
// Ports:
//   clk        in   system clock, all state on rising edge
//   reset      in   asynchronous active-high reset
//   din        in   block from tx_buffer, captured on an accepted load
//   load       in   request to send din, honoured only while ready=1
//   ready      out  high while idle
//   tx_start   out  one-cycle pulse: UART should send dout
//   dout       out  current byte, held from tx_start until its tx_done
//   tx_done    in   one-cycle pulse: UART finished the current byte
//   block_done out  one-cycle pulse after the last byte's tx_done
//
// state | meaning
// IDLE  | waiting for load; ready=1
// START | tx_start pulse for the byte in dout
// WAIT  | byte on the line, waiting for tx_done
// GAP   | idle spacing before the next byte
// DONE  | block_done pulse, then back to IDLE
module tx_shift
    import uart_pkg::*;
#(
    parameter int NUM_BYTES  = DEF_NUM_BYTES,
    parameter int GAP_CYCLES = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [BYTE_W*NUM_BYTES-1:0] din,
    input  logic                        load,
    output logic                        ready,
    output logic                        tx_start,
    output logic [BYTE_W-1:0]           dout,
    input  logic                        tx_done,
    output logic                        block_done
);

    localparam int BLK_W = BYTE_W * NUM_BYTES;
    localparam int CTR_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CTR_W-1:0] LAST_BYTE = CTR_W'(NUM_BYTES - 1);
    // The gap counter is a down-counter; reaching zero ends the gap, so it
    // is loaded with one less than the number of idle clocks.
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [ST_W-1:0]  state;
    logic [BLK_W-1:0] shift_reg;
    logic [CTR_W-1:0] ctr;
    logic [GAP_W-1:0] gap_ctr;

    assign ready = (state == ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            ctr        <= '0;
            gap_ctr    <= '0;
            dout       <= '0;
            tx_start   <= 1'b0;
            block_done <= 1'b0;
        end else begin
            tx_start   <= 1'b0;
            block_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        shift_reg <= din;
                        ctr       <= '0;
                        dout      <= din[BLK_W-1 -: BYTE_W];
                        tx_start  <= 1'b1;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        if (ctr == LAST_BYTE) begin
                            block_done <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            shift_reg <= {shift_reg[BLK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
                            ctr       <= ctr + 1'b1;
                            if (GAP_CYCLES > 0) begin
                                gap_ctr <= GAP_LOAD;
                                state   <= ST_GAP;
                            end else begin
                                // Next byte sits just below the current top byte.
                                dout     <= shift_reg[BLK_W-BYTE_W-1 -: BYTE_W];
                                tx_start <= 1'b1;
                                state    <= ST_START;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_ctr == '0) begin
                        // Shift already happened on tx_done; top byte is next.
                        dout     <= shift_reg[BLK_W-1 -: BYTE_W];
                        tx_start <= 1'b1;
                        state    <= ST_START;
                    end else begin
                        gap_ctr <= gap_ctr - 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_shift.sv
module tb_tx_shift;

    localparam int NB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with back-to-back bytes
    logic         reset0, load0, tx_done0;
    logic [127:0] din0;
    logic         ready0, tx_start0, block_done0;
    logic [7:0]   dout0;

    // Instance with three idle clocks between bytes
    logic         reset3, load3, tx_done3;
    logic [127:0] din3;
    logic         ready3, tx_start3, block_done3;
    logic [7:0]   dout3;

    tx_shift #(.NUM_BYTES(NB), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset0), .din(din0), .load(load0), .ready(ready0),
        .tx_start(tx_start0), .dout(dout0), .tx_done(tx_done0), .block_done(block_done0)
    );

    tx_shift #(.NUM_BYTES(NB), .GAP_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset3), .din(din3), .load(load3), .ready(ready3),
        .tx_start(tx_start3), .dout(dout3), .tx_done(tx_done3), .block_done(block_done3)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int ns0 = 0;
    int bd0 = 0;
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        if (tx_start0)   ns0++;
        if (block_done0) bd0++;
    end

    function automatic logic [7:0] byte_of(input logic [127:0] b, input int i);
        logic [127:0] s;
        s = b >> (8 * (NB - 1 - i));
        return s[7:0];
    endfunction

    function automatic logic [127:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic push_block(input logic [127:0] b);
        for (int i = 0; i < NB; i++) exp_q.push_back(byte_of(b, i));
    endtask

    task automatic start0(input logic [127:0] b);
        din0  = b;
        load0 = 1'b1;
        @(negedge clk);
        load0 = 1'b0;
    endtask

    // UART model for dut0: expects each tx_start one cycle after the previous
    // tx_done (or after load), checks the byte against the scoreboard, then
    // answers with tx_done dly cycles later.
    task automatic serve0(input int nbytes, input int dly, input bit spurious,
                          input int chg_at, input logic [127:0] new_din);
        logic [7:0] exp;
        logic [7:0] d0;
        int w;
        bit stable;
        for (int i = 0; i < nbytes; i++) begin
            w = 0;
            while (!tx_start0 && w < 40) begin
                @(negedge clk);
                w++;
            end
            n_checks++;
            if (!tx_start0) begin
                $display("FAIL start_timeout byte %0d: tx_start=%0b after %0d cycles, required 1", i, tx_start0, w);
                n_fail++;
                return;
            end
            n_checks++;
            if (w != 0) begin
                $display("FAIL start_latency byte %0d: waited %0d extra cycles, required 0", i, w);
                n_fail++;
            end
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++;
            if (dout0 !== exp) begin
                $display("FAIL dout byte %0d: got %02h, required %02h", i, dout0, exp);
                n_fail++;
            end
            d0 = dout0;
            stable = 1'b1;
            if (spurious) tx_done0 = 1'b1;
            for (int k = 0; k < dly; k++) begin
                @(negedge clk);
                tx_done0 = 1'b0;
                if (i == chg_at && k == 0) din0 = new_din;
                if (tx_start0 || dout0 !== d0) stable = 1'b0;
            end
            n_checks++;
            if (!stable) begin
                $display("FAIL hold byte %0d: dout/tx_start changed while waiting, required stable", i);
                n_fail++;
            end
            tx_done0 = 1'b1;
            @(negedge clk);
            tx_done0 = 1'b0;
        end
        if (nbytes == NB) begin
            n_checks++;
            if (block_done0 !== 1'b1 || ready0 !== 1'b0) begin
                $display("FAIL block_done_pulse: block_done=%0b ready=%0b, required 1 0", block_done0, ready0);
                n_fail++;
            end
            @(negedge clk);
            n_checks++;
            if (ready0 !== 1'b1 || block_done0 !== 1'b0) begin
                $display("FAIL ready_return: ready=%0b block_done=%0b, required 1 0", ready0, block_done0);
                n_fail++;
            end
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (ready0 !== 1'b1 || tx_start0 !== 1'b0 || dout0 !== 8'h00 || block_done0 !== 1'b0) begin
            $display("FAIL reset_state: ready=%0b tx_start=%0b dout=%02h block_done=%0b, required 1 0 00 0",
                     ready0, tx_start0, dout0, block_done0);
            n_fail++;
        end
        n_checks++;
        if (ready3 !== 1'b1 || tx_start3 !== 1'b0 || dout3 !== 8'h00) begin
            $display("FAIL reset_state_gap: ready=%0b tx_start=%0b dout=%02h, required 1 0 00", ready3, tx_start3, dout3);
            n_fail++;
        end
        reset0 = 1'b0;
        reset3 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [127:0] b;
        int s0, d0c;
        b = 128'h00112233445566778899AABBCCDDEEFF;
        s0 = ns0; d0c = bd0;
        push_block(b);
        start0(b);
        serve0(NB, 10, 1'b0, -1, '0);
        n_checks++;
        if (ns0 - s0 != NB || bd0 - d0c != 1) begin
            $display("FAIL basic_counts: starts=%0d block_done=%0d, required %0d 1", ns0 - s0, bd0 - d0c, NB);
            n_fail++;
        end
    endtask

    task automatic test_load_held();
        logic [127:0] a, b;
        int d0c;
        a = rand_block();
        b = rand_block();
        d0c = bd0;
        push_block(a);
        push_block(b);
        din0  = a;
        load0 = 1'b1;
        @(negedge clk);
        serve0(NB, 4, 1'b0, 7, b);
        // load still high: second block accepted in the cycle ready returns
        @(negedge clk);
        load0 = 1'b0;
        serve0(NB, 3, 1'b0, -1, '0);
        n_checks++;
        if (bd0 - d0c != 2) begin
            $display("FAIL load_held_blocks: block_done pulses=%0d, required 2", bd0 - d0c);
            n_fail++;
        end
    endtask

    task automatic test_spurious_done();
        logic [127:0] b;
        logic [7:0] d;
        int s0, d0c;
        b = rand_block();
        s0 = ns0; d0c = bd0;
        push_block(b);
        start0(b);
        serve0(NB, 5, 1'b1, -1, '0);
        n_checks++;
        if (ns0 - s0 != NB || bd0 - d0c != 1) begin
            $display("FAIL spurious_counts: starts=%0d block_done=%0d, required %0d 1", ns0 - s0, bd0 - d0c, NB);
            n_fail++;
        end
        d = byte_of(b, NB - 1);
        s0 = ns0; d0c = bd0;
        tx_done0 = 1'b1;
        @(negedge clk);
        tx_done0 = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ready0 !== 1'b1 || dout0 !== d || ns0 != s0 || bd0 != d0c) begin
            $display("FAIL idle_tx_done: ready=%0b dout=%02h starts=%0d bd=%0d, required 1 %02h 0 0",
                     ready0, dout0, ns0 - s0, bd0 - d0c, d);
            n_fail++;
        end
    endtask

    task automatic test_async_reset();
        logic [127:0] b;
        int d0c;
        b = rand_block();
        d0c = bd0;
        push_block(b);
        start0(b);
        serve0(5, 6, 1'b0, -1, '0);
        #2 reset0 = 1'b1;
        #1;
        n_checks++;
        if (tx_start0 !== 1'b0 || dout0 !== 8'h00 || ready0 !== 1'b1 || block_done0 !== 1'b0) begin
            $display("FAIL async_reset: tx_start=%0b dout=%02h ready=%0b block_done=%0b, required 0 00 1 0",
                     tx_start0, dout0, ready0, block_done0);
            n_fail++;
        end
        exp_q.delete();
        @(negedge clk);
        reset0 = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (bd0 != d0c || ready0 !== 1'b1) begin
            $display("FAIL abandon_block: block_done pulses=%0d ready=%0b, required 0 1", bd0 - d0c, ready0);
            n_fail++;
        end
        b = '1;
        push_block(b);
        start0(b);
        serve0(NB, 2, 1'b0, -1, '0);
    endtask

    task automatic test_gap();
        logic [127:0] b;
        int w;
        b = rand_block();
        din3  = b;
        load3 = 1'b1;
        @(negedge clk);
        load3 = 1'b0;
        for (int i = 0; i < NB; i++) begin
            w = 0;
            while (!tx_start3 && w < 40) begin
                @(negedge clk);
                w++;
            end
            n_checks++;
            if (!tx_start3 || w != ((i == 0) ? 0 : 3)) begin
                $display("FAIL gap_spacing byte %0d: tx_start=%0b waited %0d, required 1 %0d",
                         i, tx_start3, w, (i == 0) ? 0 : 3);
                n_fail++;
                if (!tx_start3) return;
            end
            n_checks++;
            if (dout3 !== byte_of(b, i)) begin
                $display("FAIL gap_dout byte %0d: got %02h, required %02h", i, dout3, byte_of(b, i));
                n_fail++;
            end
            repeat (4) @(negedge clk);
            tx_done3 = 1'b1;
            @(negedge clk);
            tx_done3 = 1'b0;
        end
        n_checks++;
        if (block_done3 !== 1'b1) begin
            $display("FAIL gap_block_done: got %0b, required 1", block_done3);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (ready3 !== 1'b1) begin
            $display("FAIL gap_ready: got %0b, required 1", ready3);
            n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] a, b;
        int d0c;
        a = rand_block();
        b = rand_block();
        d0c = bd0;
        push_block(a);
        push_block(b);
        start0(a);
        serve0(NB, 3, 1'b0, -1, '0);
        start0(b);
        serve0(NB, 3, 1'b0, -1, '0);
        n_checks++;
        if (bd0 - d0c != 2 || exp_q.size() != 0) begin
            $display("FAIL back_to_back: block_done=%0d leftover bytes=%0d, required 2 0", bd0 - d0c, exp_q.size());
            n_fail++;
        end
    endtask

    initial begin
        reset0 = 1'b1; load0 = 1'b0; tx_done0 = 1'b0; din0 = '0;
        reset3 = 1'b1; load3 = 1'b0; tx_done3 = 1'b0; din3 = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_load_held();
        test_spurious_done();
        test_async_reset();
        test_gap();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_shift.md
Name: tx_shift

Overview:
Block serializer for the UART return path. Accepts one 128-bit block (AES ciphertext from tx_buffer) and feeds it byte by byte, MSB byte first, to the UART transmitter using a start/done handshake. Byte order is the inverse of the receive-side shifter, so a block received and echoed leaves in its original order. Sits between tx_buffer (upstream) and the UART transmitter (downstream).

Parameters:
NUM_BYTES, 16, bytes per block; block width = 8*NUM_BYTES; counter width = clog2(NUM_BYTES).
GAP_CYCLES, 0, idle clocks inserted after each tx_done before the next tx_start (0 = back-to-back).

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
din  input  8*NUM_BYTES  block from tx_buffer; sampled only on an accepted load
load  input  1  request to send din; accepted only when ready=1
ready  output  1  high in IDLE; tx_buffer may assert load
tx_start  output  1  one-cycle pulse to UART transmitter: send dout
dout  output  8  current byte; stable from tx_start until the matching tx_done
tx_done  input  1  one-cycle pulse from UART transmitter: byte finished on line
block_done  output  1  one-cycle pulse after the last byte's tx_done; read-enable/pop to tx_buffer

Behaviour:
- Reset (async, any state): state=IDLE, shift reg=0, ctr=0, gap ctr=0, dout=0, tx_start=0, block_done=0, ready=1 (decoded from IDLE). Block in flight is abandoned; no block_done.
- States: IDLE, START, WAIT, GAP, DONE. All outputs registered except ready (= state==IDLE).
- IDLE: load=1 at edge N -> shift reg <= din, ctr <= 0, state <= START. load while not in IDLE is ignored (not queued).
- START (one cycle): tx_start=1, dout = shift reg[top 8 bits]; state <= WAIT. Load at N -> tx_start high in cycle N+1 with dout=din[127:120].
- WAIT: hold dout, tx_start=0. On tx_done: if ctr==NUM_BYTES-1 -> DONE; else shift reg <<= 8 (zero fill), ctr+1, -> GAP if GAP_CYCLES>0 else START.
- tx_done outside WAIT (incl. the START cycle) is ignored.
- GAP: count GAP_CYCLES clocks, then START.
- DONE (one cycle): block_done=1; -> IDLE. tx_done at M (last byte) -> block_done in cycle M+1, ready in cycle M+2.
- Block latency, GAP_CYCLES=0: 16 tx_start pulses; each tx_start exactly 1 cycle after the previous tx_done.
- dout changes only when entering START; holds the last byte through DONE/IDLE until the next load.
- Counter never wraps within a block; it is reloaded to 0 on each accepted load.

Decomposition:
- Shared package/header (uart_pkg): state encodings (IDLE=0, START=1, WAIT=2, GAP=3, DONE=4), BYTE_W=8, default NUM_BYTES=16. rx_shift and tx_shift share these.
- No sub-module; single FSM plus shift register, counter, and gap counter. Implementation is 120-200 lines.

Test Plan:
1. Reset, then load with din=0x00112233445566778899AABBCCDDEEFF; UART model returns tx_done 10 cycles after each tx_start -> dout sequence 00,11,...,FF over 16 tx_start pulses; block_done exactly once, 1 cycle after the 16th tx_done; ready high the following cycle.
2. load held high continuously during a transmission with din changed mid-block -> bytes still come from the first block; a second block starts only after ready returns.
3. tx_done asserted in the same cycle as tx_start, and a spurious tx_done in IDLE -> both ignored; byte count stays 16; dout unchanged.
4. Reset asserted asynchronously after the 5th tx_done -> outputs 0 immediately and ready=1; no block_done; next load with 0xFFFF...FF sends 16 bytes of FF from the start.
5. GAP_CYCLES=3 -> each tx_start occurs exactly 4 cycles after the preceding tx_done; first tx_start still 1 cycle after load.
6. Two back-to-back blocks (A then B, load on the cycle ready rises) -> 32 bytes in order A0..A15, B0..B15; two block_done pulses.
